// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle control FSM and the shared datapath.
//
// Memory handshake: the controller holds MemRead or MemWrite (together with
// AdrSrc) steady for as long as it stays in an access state. The access
// completes on the rising clock edge where mem_ready is 1. The controller only
// leaves the access state on that edge. mem_ready is ignored in every state that
// does not request memory.
interface multicycle_ctrl_if;
  // datapath -> controller
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  // controller -> datapath
  logic        MemRead;
  logic        MemWrite;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic        shift_right_type;
  logic [2:0]  ImmSrc;
  logic        illegal;

  modport master (
    input  instr, zero, mem_ready,
    output MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, shift_right_type,
           ImmSrc, illegal
  );

  modport slave (
    output instr, zero, mem_ready,
    input  MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, shift_right_type,
           ImmSrc, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I-subset core. One datapath phase per
// cycle, memory accesses wait on mem_ready, and every return to FETCH from
// another state counts one retired instruction. state_dbg exposes the state.
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_if.master    bus,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [3:0]           state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr_bits;

  assign opcode   = bus.instr[6:0];
  assign funct3   = bus.instr[14:12];
  assign funct7_5 = bus.instr[30];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic       shift_right_type, illegal;

  // funct3 to ALU operation; sub_bit selects sub for 000 (register form only)
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_bit);
    case (f3)
      3'b000:  alu_dec = sub_bit ? 3'b001 : 3'b000;
      3'b001:  alu_dec = 3'b110;
      3'b010:  alu_dec = 3'b101;
      3'b011:  alu_dec = 3'b101;
      3'b100:  alu_dec = 3'b100;
      3'b101:  alu_dec = 3'b111;
      3'b110:  alu_dec = 3'b011;
      default: alu_dec = 3'b010;
    endcase
  endfunction

  // Next state and datapath controls; rst forces every control to 0
  always_comb begin
    state_d          = state_q;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    adr_src          = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    reg_write        = 1'b0;
    result_src       = 2'b00;
    alu_src_a        = 2'b00;
    alu_src_b        = 2'b00;
    alu_control      = 3'b000;
    imm_src          = 3'b000;
    shift_right_type = 1'b0;
    illegal          = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // branch target (or J-imm target for jal) computed speculatively
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a        = 2'b10;
        alu_src_b        = 2'b00;
        alu_control      = alu_dec(funct3, funct7_5);
        shift_right_type = (funct3 == 3'b101) && funct7_5;
        state_d          = S_ALUWB;
      end
      S_EXECI: begin
        // addi has no subtract form, so bit 30 only matters for srai
        alu_src_a        = 2'b10;
        alu_src_b        = 2'b01;
        imm_src          = 3'b000;
        alu_control      = alu_dec(funct3, 1'b0);
        shift_right_type = (funct3 == 3'b101) && funct7_5;
        state_d          = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = 3'b001;
        result_src  = 2'b00;
        pc_write    = funct3[0] ? ~bus.zero : bus.zero;
        state_d     = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = 3'b000;
        state_d   = S_JAL;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while OldPC + 4 forms the link value
        result_src = 2'b00;
        pc_write   = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_TRAP;
    endcase

    if (rst) begin
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      adr_src          = 1'b0;
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      reg_write        = 1'b0;
      result_src       = 2'b00;
      alu_src_a        = 2'b00;
      alu_src_b        = 2'b00;
      alu_control      = 3'b000;
      imm_src          = 3'b000;
      shift_right_type = 1'b0;
      illegal          = 1'b0;
    end
  end

  // Retire count: one per return to FETCH from any other state
  always_comb begin
    instret_d = instret_q;
    if (state_q != S_FETCH && state_d == S_FETCH) instret_d = instret_q + CNT_WIDTH'(1);
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign bus.MemRead          = mem_read;
  assign bus.MemWrite         = mem_write;
  assign bus.AdrSrc           = adr_src;
  assign bus.IRWrite          = ir_write;
  assign bus.PCWrite          = pc_write;
  assign bus.RegWrite         = reg_write;
  assign bus.ResultSrc        = result_src;
  assign bus.ALUSrcA          = alu_src_a;
  assign bus.ALUSrcB          = alu_src_b;
  assign bus.ALUControl       = alu_control;
  assign bus.shift_right_type = shift_right_type;
  assign bus.ImmSrc           = imm_src;
  assign bus.illegal          = illegal;
  assign instret              = instret_q;
  assign state_dbg            = state_q;

endmodule
